bp_stall_window_profiler: RTL and testbench
===========================================

Name: bp_stall_window_profiler

Overview:
Parametrised successor to the per-core stall-reason counters. It takes a commit-aligned stall-reason vector and an instret strobe and keeps one saturating counter per reason, plus a cycle counter and an instret counter. It adds programmable sampling windows, manual snapshots, sticky overflow flags and a valid/ready readout port, so host-side software can read stable histograms without stopping the core. It sits beside the core, after the stall-attribution pipe, and its read port connects to the cosim CSR shim.

Parameters:
num_reasons_p, 24, number of stall reasons; reason 0 is "unknown"
ctr_width_p, 32, width of every counter and snapshot register
window_width_p, 20, width of the window-length input and the window counter
addr_width_lp, clog2(num_reasons_p+2), read address width (derived)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
freeze_i  in  1  core frozen; no counting
en_i  in  1  counting enable
reason_i  in  num_reasons_p  stall-reason bits for this cycle, already aligned to commit
instret_i  in  1  instruction retired this cycle
window_i  in  window_width_p  window length in active cycles; 0 = free-running
clear_i  in  1  clear live counters
snap_i  in  1  manual snapshot request
rd_v_i  in  1  read request valid
rd_addr_i  in  addr_width_lp  0..N-1 = reason counts, N = cycles, N+1 = instret (N = num_reasons_p)
rd_ready_o  out  1  read request accepted when high
rd_v_o  out  1  read response valid
rd_data_o  out  ctr_width_p  read data
rd_yumi_i  in  1  response consumed
snap_done_o  out  1  one-cycle pulse the cycle after any snapshot is taken
ovf_o  out  num_reasons_p+2  sticky saturation flags, same indexing as rd_addr_i

Behaviour:
- Reset: all live counters, snapshots, ovf_o, the window counter, rd_v_o, rd_data_o and snap_done_o go to 0. rd_ready_o is 1.
- An active cycle is en_i & ~freeze_i. On each active cycle:
  - The cycle counter increments by 1.
  - If instret_i is high, the instret counter increments by 1.
  - Otherwise exactly one reason counter increments: the lowest-index set bit of reason_i, or reason 0 if reason_i is all zero.
  - Invariant when no counter has saturated: sum of reason counters + instret counter == cycle counter.
- Saturation: a counter at 2^ctr_width_p-1 holds its value. Its ovf bit is set on any attempted increment at max and stays set until clear_i or reset.
- Window:
  - Applies when window_i != 0. The window counter increments on active cycles.
  - On an active cycle where window count >= window_i-1, that cycle is the window end:
    - The snapshot captures the live values including this cycle's increment.
    - Live counters and the window counter are 0 on the next cycle.
    - ovf flags are kept.
  - Reducing window_i below the current window count ends the window on the next active cycle.
  - window_i = 0 disables windowing and holds the window counter at 0.
- snap_i: the snapshot captures the live values including this cycle's increment. Live counters are unchanged. snap_i on a window-end cycle produces one snapshot.
- clear_i:
  - On the next cycle, live counters, the window counter and ovf are 0. This cycle's increment is discarded from the live counters.
  - Snapshot registers are unaffected, except that clear_i together with snap_i or a window end still snapshots the pre-clear values including this cycle's increment.
- snap_done_o: 1 exactly one cycle after any snapshot capture.
- Read handshake:
  - rd_ready_o = ~rd_v_o.
  - A request is accepted when rd_v_i & rd_ready_o. On the next cycle rd_v_o=1 and rd_data_o = snapshot[rd_addr_i], latched at acceptance.
  - rd_data_o holds stable until rd_yumi_i; rd_v_o is 0 the cycle after rd_yumi_i. rd_yumi_i while rd_v_o=0 is ignored.
  - An out-of-range address returns 0.
  - A snapshot taken while a response is pending does not change the held rd_data_o.
  - Only one read is outstanding at a time, so throughput is one read per 2 cycles.
- Asserting reset_n_i low mid-read or mid-window returns everything to reset values immediately. A pending response is dropped.

Test Plan:
- Reset, en_i=1, instret_i=1 for 10 cycles, snap_i, read addr N+1 then N -> rd_data_o=10 then 10; all reason snapshots 0.
- reason_i=24'b1100 for 5 active cycles with instret_i=0, then reason_i=0 for 3 cycles, snap, read -> reason2=5, reason0=3, reason3=0, cycles=8.
- window_i=4, en_i=1, instret_i=1 continuously -> snap_done_o pulses at cycles 5, 9, 13; every instret snapshot is 4; freeze_i=1 for 2 cycles inside a window stretches that window to 6 clock cycles.
- ctr_width_p=4, 20 cycles of reason 1 -> snapshot reason1=15, ovf_o[1]=1, ovf_o[N]=1 (cycles); clear_i -> ovf_o=0 and live counters 0.
- Issue a read and hold rd_yumi_i=0 for 5 cycles while snap_i fires -> rd_data_o unchanged and rd_ready_o=0 until yumi; rd_v_o=0 the next cycle.
- clear_i and snap_i in the same cycle after 7 instret cycles -> instret snapshot=8 (includes that cycle's increment), live instret=0 on the next cycle.

Source files
------------

// File: rtl/bp_stall_window_profiler.sv
// Stall-reason histogram profiler with sampling windows,
// snapshots, sticky saturation flags and a valid/ready read port.
module bp_stall_window_profiler #(
  parameter int num_reasons_p = 24,
  parameter int ctr_width_p = 32,
  parameter int window_width_p = 20,
  localparam int addr_width_lp = $clog2(num_reasons_p+2)
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic freeze_i,
  input  logic en_i,
  input  logic [num_reasons_p-1:0] reason_i,
  input  logic instret_i,
  input  logic [window_width_p-1:0] window_i,
  input  logic clear_i,
  input  logic snap_i,
  input  logic rd_v_i,
  input  logic [addr_width_lp-1:0] rd_addr_i,
  output logic rd_ready_o,
  output logic rd_v_o,
  output logic [ctr_width_p-1:0] rd_data_o,
  input  logic rd_yumi_i,
  output logic snap_done_o,
  output logic [num_reasons_p+1:0] ovf_o
);

  localparam int nc_lp = num_reasons_p + 2;
  localparam int cyc_lp = num_reasons_p;
  localparam int ins_lp = num_reasons_p + 1;
  localparam logic [ctr_width_p-1:0] max_lp = '1;

  logic [ctr_width_p-1:0] live_r [nc_lp];
  logic [ctr_width_p-1:0] snap_r [nc_lp];
  logic [ctr_width_p-1:0] nxt [nc_lp];
  logic [nc_lp-1:0] hit;
  logic [nc_lp-1:0] sat;
  logic [nc_lp-1:0] ovf_r;
  logic [window_width_p-1:0] win_r;
  logic [addr_width_lp-1:0] sel;
  logic [ctr_width_p-1:0] rd_mux;
  logic active;
  logic win_end;
  logic take;

  assign active = en_i & ~freeze_i;
  assign win_end = active & (window_i != '0)
    & (win_r >= window_i - window_width_p'(1));
  assign take = snap_i | win_end;
  assign ovf_o = ovf_r;
  assign rd_ready_o = ~rd_v_o;

  // Charge instret first, else the lowest set reason, else reason 0
  always_comb begin
    sel = '0;
    if (instret_i) begin
      sel = addr_width_lp'(ins_lp);
    end else begin
      for (int i = num_reasons_p-1; i >= 0; i--) begin
        if (reason_i[i]) sel = addr_width_lp'(i);
      end
    end
  end

  // Saturating next values including this cycle's increment
  always_comb begin
    hit = '0;
    sat = '0;
    for (int i = 0; i < nc_lp; i++) begin
      hit[i] = active & ((i == cyc_lp) | (sel == addr_width_lp'(i)));
      sat[i] = hit[i] & (live_r[i] == max_lp);
      nxt[i] = (hit[i] && !sat[i])
        ? live_r[i] + ctr_width_p'(1) : live_r[i];
    end
  end

  // Read mux over snapshot registers; unmapped addresses read 0
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < nc_lp; i++) begin
      if (rd_addr_i == addr_width_lp'(i)) rd_mux = snap_r[i];
    end
  end

  // Live counters, window counter and sticky overflow flags
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < nc_lp; i++) live_r[i] <= '0;
      win_r <= '0;
      ovf_r <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < nc_lp; i++) live_r[i] <= '0;
      win_r <= '0;
      ovf_r <= '0;
    end else begin
      for (int i = 0; i < nc_lp; i++) begin
        live_r[i] <= win_end ? '0 : nxt[i];
      end
      ovf_r <= ovf_r | sat;
      if (win_end || window_i == '0) win_r <= '0;
      else if (active) win_r <= win_r + window_width_p'(1);
    end
  end

  // Snapshot capture on manual request or window end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < nc_lp; i++) snap_r[i] <= '0;
      snap_done_o <= 1'b0;
    end else begin
      if (take) begin
        for (int i = 0; i < nc_lp; i++) snap_r[i] <= nxt[i];
      end
      snap_done_o <= take;
    end
  end

  // Single outstanding read; data held until consumed
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_v_o <= 1'b0;
      rd_data_o <= '0;
    end else if (rd_v_o) begin
      if (rd_yumi_i) rd_v_o <= 1'b0;
    end else if (rd_v_i) begin
      rd_v_o <= 1'b1;
      rd_data_o <= rd_mux;
    end
  end

endmodule

// File: tb/tb_bp_stall_window_profiler.sv
// Bench for bp_stall_window_profiler: directed scenarios plus
// random traffic against a behavioural histogram model.
module tb_bp_stall_window_profiler;

  localparam int N = 24;
  localparam int W = 4;
  localparam int WW = 20;
  localparam int NC = N + 2;
  localparam int AW = $clog2(N+2);
  localparam int MAXV = (1 << W) - 1;

  logic clk = 1'b0;
  logic reset_n;
  logic freeze, en, instret, clear, snap;
  logic [N-1:0] reason;
  logic [WW-1:0] window;
  logic rd_v_i, rd_yumi;
  logic [AW-1:0] rd_addr;
  logic rd_ready, rd_v_o, snap_done;
  logic [W-1:0] rd_data;
  logic [NC-1:0] ovf;

  int n_cmp = 0;
  int n_bad = 0;

  int m_live [NC];
  int m_snap [NC];
  bit m_ovf [NC];
  int m_w;
  bit m_rv;
  int m_rdata;
  bit m_done;

  always #5 clk = ~clk;

  bp_stall_window_profiler #(
    .num_reasons_p(N),
    .ctr_width_p(W),
    .window_width_p(WW)
  ) dut (
    .clk_i(clk),
    .reset_n_i(reset_n),
    .freeze_i(freeze),
    .en_i(en),
    .reason_i(reason),
    .instret_i(instret),
    .window_i(window),
    .clear_i(clear),
    .snap_i(snap),
    .rd_v_i(rd_v_i),
    .rd_addr_i(rd_addr),
    .rd_ready_o(rd_ready),
    .rd_v_o(rd_v_o),
    .rd_data_o(rd_data),
    .rd_yumi_i(rd_yumi),
    .snap_done_o(snap_done),
    .ovf_o(ovf)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_live[i] = 0;
      m_snap[i] = 0;
      m_ovf[i] = 0;
    end
    m_w = 0;
    m_rv = 0;
    m_rdata = 0;
    m_done = 0;
  endtask

  function automatic logic [NC-1:0] ovf_vec();
    logic [NC-1:0] v;
    for (int i = 0; i < NC; i++) v[i] = m_ovf[i];
    return v;
  endfunction

  // One clock of the histogram rules applied to the current inputs
  task automatic model_step();
    int nv [NC];
    bit hitmax [NC];
    int tgt;
    bit act, wend, take;
    act = en && !freeze;
    if (m_rv) begin
      if (rd_yumi) m_rv = 0;
    end else if (rd_v_i) begin
      m_rv = 1;
      m_rdata = (int'(rd_addr) < NC) ? m_snap[rd_addr] : 0;
    end
    for (int i = 0; i < NC; i++) begin
      nv[i] = m_live[i];
      hitmax[i] = 0;
    end
    if (act) begin
      tgt = -1;
      if (instret) tgt = N + 1;
      else
        for (int i = 0; i < N; i++)
          if (reason[i] && tgt < 0) tgt = i;
      if (tgt < 0) tgt = 0;
      foreach (nv[i]) begin
        if (i == N || i == tgt) begin
          if (nv[i] == MAXV) hitmax[i] = 1;
          else nv[i] = nv[i] + 1;
        end
      end
    end
    wend = act && window != 0 && (m_w + 1 >= int'(window));
    take = snap || wend;
    if (take) for (int i = 0; i < NC; i++) m_snap[i] = nv[i];
    m_done = take;
    if (clear) begin
      for (int i = 0; i < NC; i++) begin
        m_live[i] = 0;
        m_ovf[i] = 0;
      end
      m_w = 0;
    end else begin
      for (int i = 0; i < NC; i++) begin
        m_live[i] = wend ? 0 : nv[i];
        m_ovf[i] = m_ovf[i] | hitmax[i];
      end
      if (wend || window == 0) m_w = 0;
      else if (act) m_w = m_w + 1;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("rd_v", rd_v_o, m_rv);
    chk("rd_ready", rd_ready, !m_rv);
    chk("rd_data", rd_data, m_rdata);
    chk("snap_done", snap_done, m_done);
    chk("ovf", ovf, ovf_vec());
  endtask

  task automatic idle();
    freeze = 0; en = 0; instret = 0; clear = 0; snap = 0;
    reason = '0; rd_v_i = 0; rd_yumi = 0; rd_addr = '0;
  endtask

  task automatic do_snap();
    idle();
    snap = 1;
    step();
    snap = 0;
  endtask

  task automatic do_clear();
    idle();
    clear = 1;
    step();
    clear = 0;
  endtask

  task automatic rd(input int a, input int exp, input string tag);
    rd_addr = AW'(a);
    rd_v_i = 1;
    step();
    rd_v_i = 0;
    chk(tag, rd_data, exp);
    rd_yumi = 1;
    step();
    rd_yumi = 0;
  endtask

  initial begin
    int first, second;
    int held;
    idle();
    window = '0;
    reset_n = 0;
    model_reset();
    #12;
    chk("rst_ready", rd_ready, 1);
    chk("rst_v", rd_v_o, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_done", snap_done, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    reset_n = 1;

    // ten retired instructions
    en = 1; instret = 1;
    repeat (10) step();
    do_snap();
    rd(N + 1, 10, "ins10");
    rd(N, 10, "cyc10");
    rd(0, 0, "r0_zero");
    rd(5, 0, "r5_zero");

    // reason priority and the unknown bucket
    do_clear();
    en = 1; reason = 24'b1100;
    repeat (5) step();
    reason = '0;
    repeat (3) step();
    do_snap();
    rd(2, 5, "r2_five");
    rd(0, 3, "r0_three");
    rd(3, 0, "r3_zero");
    rd(N, 8, "cyc8");

    // windows of four active cycles
    do_clear();
    window = 20'd4;
    en = 1; instret = 1;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("win_done", snap_done, (k % 4) == 0);
    end
    rd_addr = AW'(N + 1);
    rd_v_i = 1;
    step();
    rd_v_i = 0;
    chk("win_ins4", rd_data, 4);
    rd_yumi = 1;
    step();
    rd_yumi = 0;

    // freeze stretches one window to six clocks
    clear = 1;
    step();
    clear = 0;
    first = 0;
    second = 0;
    for (int j = 1; j <= 12; j++) begin
      freeze = (j == 2 || j == 3);
      step();
      if (snap_done && first == 0) first = j;
      else if (snap_done && second == 0) second = j;
    end
    freeze = 0;
    chk("frz_first", first, 6);
    chk("frz_second", second, 10);
    window = '0;

    // saturation and sticky flags
    do_clear();
    en = 1; reason = 24'b10;
    repeat (20) step();
    do_snap();
    rd(1, 15, "sat_r1");
    chk("ovf_r1", ovf[1], 1);
    chk("ovf_cyc", ovf[N], 1);
    do_clear();
    chk("ovf_clr", ovf, 0);
    do_snap();
    rd(1, 0, "clr_r1");
    rd(N, 0, "clr_cyc");

    // held response while snapshots keep firing
    en = 1; instret = 1;
    repeat (3) step();
    do_snap();
    rd_addr = AW'(N + 1);
    rd_v_i = 1;
    step();
    rd_v_i = 0;
    held = m_rdata;
    chk("held_val", rd_data, 3);
    en = 1; instret = 1; snap = 1;
    repeat (5) begin
      step();
      chk("held_data", rd_data, held);
      chk("held_rdy", rd_ready, 0);
    end
    idle();
    rd_yumi = 1;
    step();
    rd_yumi = 0;
    chk("yumi_v", rd_v_o, 0);

    // clear plus snap keeps this cycle's increment
    do_clear();
    en = 1; instret = 1;
    repeat (7) step();
    clear = 1; snap = 1;
    step();
    idle();
    rd(N + 1, 8, "cs_ins8");
    do_snap();
    rd(N + 1, 0, "cs_live0");

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      if (c % 60 == 0) window = WW'($urandom_range(0, 7));
      en = ($urandom_range(0, 9) != 0);
      freeze = ($urandom_range(0, 7) == 0);
      instret = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: reason = '0;
        1: reason = N'(1) << $urandom_range(0, N - 1);
        default: reason = N'($urandom);
      endcase
      clear = ($urandom_range(0, 99) == 0);
      snap = ($urandom_range(0, 9) == 0);
      rd_v_i = $urandom_range(0, 1);
      rd_addr = AW'($urandom_range(0, (1 << AW) - 1));
      rd_yumi = $urandom_range(0, 1);
      step();
    end

    // reset in the middle of a pending read
    idle();
    window = '0;
    rd_addr = AW'(N);
    rd_v_i = 1;
    step();
    rd_v_i = 0;
    #3;
    reset_n = 0;
    #1;
    model_reset();
    chk("arst_v", rd_v_o, 0);
    chk("arst_rdy", rd_ready, 1);
    chk("arst_data", rd_data, 0);
    chk("arst_ovf", ovf, 0);
    @(negedge clk);
    reset_n = 1;
    do_snap();
    rd(N, 0, "arst_cyc");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
